seq_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider for the calculator datapath.

---
 rtl/seq_divider.sv | 106 ++++++++++
 tb/tb_seq_divider.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtract per clock, MSB first.
// Result bus is {remainder, quotient}; divide-by-zero completes immediately with E set.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   inputP,
  input  logic [WIDTH-1:0]   inputQ,
  output logic [2*WIDTH-1:0] S,
  output logic               busy,
  output logic               done,
  output logic               E
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic [WIDTH-1:0]   quo_reg, quo_next;
  logic [WIDTH-1:0]   div_reg, div_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [2*WIDTH-1:0] s_reg, s_next;
  logic               e_reg, e_next;

  logic [WIDTH:0]     rem_shift;
  logic [WIDTH+1:0]   trial;
  logic               trial_ok;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;

  // One restoring step; an extra sign bit makes the borrow visible.
  assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
  assign trial     = {1'b0, rem_shift} - {2'b00, div_reg};
  assign trial_ok  = ~trial[WIDTH+1];
  assign quo_step  = {quo_reg[WIDTH-2:0], trial_ok};
  assign rem_step  = trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    quo_next   = quo_reg;
    div_next   = div_reg;
    count_next = count_reg;
    s_next     = s_reg;
    e_next     = e_reg;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          if (inputQ == '0) begin
            state_next = DONE;
            s_next     = {inputP, {WIDTH{1'b1}}};
            e_next     = 1'b1;
          end else begin
            state_next = RUN;
            rem_next   = '0;
            quo_next   = inputP;
            div_next   = inputQ;
            count_next = '0;
          end
        end
      end
      RUN: begin
        rem_next   = rem_step;
        quo_next   = quo_step;
        count_next = count_reg + 1'b1;
        if (count_reg == CW'(WIDTH - 1)) begin
          state_next = DONE;
          s_next     = {rem_step, quo_step};
          e_next     = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      quo_reg   <= '0;
      div_reg   <= '0;
      count_reg <= '0;
      s_reg     <= '0;
      e_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      quo_reg   <= quo_next;
      div_reg   <= div_next;
      count_reg <= count_next;
      s_reg     <= s_next;
      e_reg     <= e_next;
    end
  end

  assign S    = s_reg;
  assign E    = e_reg;
  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: handshake timing, divide-by-zero, ignored start,
// mid-run reset, back-to-back start and a small randomised sweep.
module tb_seq_divider;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   inputP = '0;
  logic [W-1:0]   inputQ = '0;
  logic [2*W-1:0] S;
  logic           busy;
  logic           done;
  logic           E;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .inputP(inputP), .inputQ(inputQ),
    .S(S), .busy(busy), .done(done), .E(E)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // busy and done must never overlap
  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%b done=%b required busy=0", busy, done);
      end
    end
  end

  // Launch one op, wait for done (bounded). lat counts edges after edge 0.
  task automatic do_op(input logic [W-1:0] p, input logic [W-1:0] q,
                       output logic [2*W-1:0] s, output logic e,
                       output int lat, output int busy_cycles);
    @(negedge clk);
    inputP = p; inputQ = q; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    s = S; e = E;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({S, busy, done, E} !== {32'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: S=%h busy=%b done=%b E=%b required all 0", S, busy, done, E);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("reset: S=%h busy=%b done=%b E=%b", S, busy, done, E);
  endtask

  task automatic test_basic();
    logic [2*W-1:0] s; logic e; int lat, bc;
    do_op(16'd100, 16'd7, s, e, lat, bc);
    $display("100/7: S=%h E=%b lat=%0d busy_cycles=%0d", s, e, lat, bc);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL basic_latency: got %0d required 16", lat); end
    checks++;
    if (bc !== 16) begin errors++; $display("FAIL basic_busy: got %0d required 16", bc); end
    checks++;
    if (s !== 32'h0002_000E) begin errors++; $display("FAIL basic_result: got %h required 0002000e", s); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL basic_e: got %b required 0", e); end
    @(posedge clk); #1;
    checks++;
    if ({done, busy, S} !== {2'b00, 32'h0002_000E}) begin
      errors++;
      $display("FAIL basic_hold: done=%b busy=%b S=%h required 0 0 0002000e", done, busy, S);
    end
  endtask

  task automatic test_extremes();
    logic [2*W-1:0] s; logic e; int lat, bc;
    do_op(16'hFFFF, 16'h0001, s, e, lat, bc);
    $display("ffff/1: S=%h E=%b lat=%0d", s, e, lat);
    checks++;
    if ({s, e} !== {32'h0000_FFFF, 1'b0}) begin
      errors++; $display("FAIL max_by_one: got S=%h E=%b required 0000ffff 0", s, e);
    end
    do_op(16'd3, 16'd10, s, e, lat, bc);
    $display("3/10: S=%h E=%b lat=%0d", s, e, lat);
    checks++;
    if ({s, e} !== {32'h0003_0000, 1'b0}) begin
      errors++; $display("FAIL small_by_large: got S=%h E=%b required 00030000 0", s, e);
    end
  endtask

  task automatic test_div_zero();
    logic [2*W-1:0] s; logic e; int lat, bc;
    do_op(16'd5, 16'd0, s, e, lat, bc);
    $display("5/0: S=%h E=%b lat=%0d busy_cycles=%0d", s, e, lat, bc);
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL dz_latency: got %0d required 0", lat); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL dz_busy: got %b required 0", busy); end
    checks++;
    if ({s, e} !== {32'h0005_FFFF, 1'b1}) begin
      errors++; $display("FAIL dz_result: got S=%h E=%b required 0005ffff 1", s, e);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy, E} !== 3'b001) begin
      errors++; $display("FAIL dz_after: done=%b busy=%b E=%b required 0 0 1", done, busy, E);
    end
  endtask

  task automatic test_start_ignored();
    int lat = 0;
    @(negedge clk);
    inputP = 16'd100; inputQ = 16'd7; start = 1'b1;
    @(posedge clk); #1;                     // edge 0
    start = 1'b0;
    repeat (4) @(posedge clk);              // edges 1..4
    @(negedge clk);
    inputP = 16'd50; inputQ = 16'd5; start = 1'b1;
    @(posedge clk); #1;                     // edge 5
    start = 1'b0;
    lat = 5;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    $display("100/7 with start at edge 5: S=%h E=%b lat=%0d", S, E, lat);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL ignore_latency: got %0d required 16", lat); end
    checks++;
    if (S !== 32'h0002_000E) begin errors++; $display("FAIL ignore_result: got %h required 0002000e", S); end
  endtask

  task automatic test_mid_reset();
    logic [2*W-1:0] s; logic e; int lat, bc;
    @(negedge clk);
    inputP = 16'd1000; inputQ = 16'd3; start = 1'b1;
    @(posedge clk); #1;                     // edge 0
    start = 1'b0;
    repeat (8) @(posedge clk);              // edge 8
    #1 rst = 1'b1;
    #1;
    $display("reset during 1000/3: S=%h busy=%b done=%b", S, busy, done);
    checks++;
    if ({S, busy, done, E} !== {32'h0, 3'b000}) begin
      errors++; $display("FAIL midreset: S=%h busy=%b done=%b E=%b required all 0", S, busy, done, E);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL midreset_quiet: done=%b busy=%b required 0 0", done, busy);
    end
    do_op(16'd9, 16'd2, s, e, lat, bc);
    $display("9/2 after reset: S=%h E=%b lat=%0d", s, e, lat);
    checks++;
    if (s !== 32'h0001_0004) begin errors++; $display("FAIL midreset_fresh: got %h required 00010004", s); end
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    int first_cyc, second_cyc;
    @(negedge clk);
    inputP = 16'd100; inputQ = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    first_cyc = cyc;
    checks++;
    if (S !== 32'h0002_000E) begin errors++; $display("FAIL b2b_first: got %h required 0002000e", S); end
    inputP = 16'd9; inputQ = 16'd2;         // start still high through DONE
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b required 1", busy); end
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    second_cyc = cyc;
    $display("back-to-back: first S=0002000e, second S=%h gap=%0d", S, second_cyc - first_cyc);
    checks++;
    if (second_cyc - first_cyc !== 17) begin
      errors++; $display("FAIL b2b_gap: got %0d required 17", second_cyc - first_cyc);
    end
    checks++;
    if (S !== 32'h0001_0004) begin errors++; $display("FAIL b2b_second: got %h required 00010004", S); end
  endtask

  task automatic test_sweep();
    logic [2*W-1:0] s; logic e; int lat, bc;
    logic [W-1:0] p, q, quo, rem;
    for (int i = 0; i < 12; i++) begin
      p = W'($urandom);
      q = (i % 3 == 0) ? W'($urandom_range(1, 15)) : W'($urandom_range(1, 65535));
      do_op(p, q, s, e, lat, bc);
      quo = s[W-1:0];
      rem = s[2*W-1:W];
      $display("sweep %0d/%0d: quo=%0d rem=%0d E=%b", p, q, quo, rem, e);
      checks++;
      if ({s, e} !== {W'(p % q), W'(p / q), 1'b0}) begin
        errors++; $display("FAIL sweep_result: %0d/%0d got S=%h required %h", p, q, s, {W'(p % q), W'(p / q)});
      end
      checks++;
      if ((32'(quo) * 32'(q) + 32'(rem) !== 32'(p)) || (rem >= q)) begin
        errors++; $display("FAIL sweep_identity: %0d/%0d got quo=%0d rem=%0d", p, q, quo, rem);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
